mem_access_sequencer: RTL
=========================

Name: mem_access_sequencer

Overview:
- Sequences every CPU load/store onto a single-ported, word-wide, handshaked memory bus. Extracts sub-word loads with sign/zero extension. Implements sub-word stores as read-modify-write.
- Sits between the CPU execute stage and the memory/VRAM bus.
- Checks alignment and access size, and enforces a bus timeout.

Parameters:
ADDR_W, 32, CPU byte-address width; the memory word address is ADDR_W-2 bits
TIMEOUT, 255, max cycles waiting for mem_gnt or mem_rvalid before an error response; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_valid  in  1  request valid
cpu_ready  out  1  request accepted when cpu_valid & cpu_ready at a clk edge
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  byte address
cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
cpu_zext  in  1  loads: 1 = zero-extend, 0 = sign-extend
cpu_wdata  in  32  store data, LSB-aligned
cpu_resp_valid  out  1  one-cycle response pulse
cpu_rdata  out  32  load result; 0 for stores and errors
cpu_err  out  1  qualified by cpu_resp_valid
mem_req  out  1  bus request, held until mem_gnt
mem_we  out  1  write request
mem_addr  out  ADDR_W-2  word address
mem_wdata  out  32  write word
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid; arrives at least 1 cycle after the read mem_gnt
mem_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - cpu_ready=1, cpu_resp_valid=0, cpu_rdata=0, cpu_err=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Timeout counter=0.
  - Reset mid-transaction abandons the access without a response; mem_req drops immediately.
- Registered outputs: all outputs are registered. cpu_ready=1 only in IDLE.
- Capture on accept: addr, size, zext, we, wdata are latched.
- Error checks at accept:
  - The access is illegal if size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]≠00.
  - An illegal access goes to RESP with err=1 and rdata=0. No bus activity occurs.
- States:
  - IDLE: on accept with a legal access, go to RD_REQ, except a word store goes to WR_REQ.
  - RD_REQ: mem_req=1, mem_we=0, mem_addr=addr[ADDR_W-1:2]. On mem_gnt, go to RD_WAIT.
  - RD_WAIT: mem_req=0. On mem_rvalid:
    - Load: latch the extracted result and go to RESP.
    - Store (byte/half): merge and go to WR_REQ.
  - WR_REQ: mem_req=1, mem_we=1, same mem_addr, mem_wdata = merged word. On mem_gnt, go to RESP.
  - RESP: cpu_resp_valid=1 for exactly one cycle, then IDLE. cpu_ready stays 0 in RESP, so there is no back-to-back accept.
- Load extraction:
  - byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
  - Upper bits are filled with ~zext & MSB.
  - Word loads pass rdata unchanged.
- Store merge:
  - byte: wdata[7:0] replaces byte lane addr[1:0]; all other lanes keep mem_rdata.
  - half: wdata[15:0] replaces the half selected by addr[1].
  - Word stores bypass the read and use wdata directly.
- Timeout:
  - The counter clears on every state entry and counts each cycle spent in RD_REQ, RD_WAIT, or WR_REQ.
  - When count = TIMEOUT-1 without the awaited event: drop mem_req, go to RESP with err=1, rdata=0.
  - A late mem_rvalid or mem_gnt arriving in IDLE or RESP is ignored.
- Simultaneous events:
  - mem_gnt and mem_rvalid in the same cycle in RD_REQ: mem_rvalid is ignored (protocol guarantees ≥1 cycle gap).
  - Awaited event on the same cycle as the timeout: the event wins.
- Minimum latencies (mem_gnt the same cycle as req, mem_rvalid 1 cycle after mem_gnt):
  - load: accept at edge E; resp_valid high in cycle E+3.
  - word store: resp_valid high in cycle E+2.
  - sub-word store: resp_valid high in cycle E+4.
  - error: resp_valid high in cycle E+1.

Test Plan:
- Memory word 0x8844_22F1 at word 1; load byte addr 0x7, zext=0 -> one read at mem_addr=1; rdata=0xFFFF_FF88, err=0. Same access with zext=1 -> 0x0000_0088.
- Same memory word; store half addr 0x6, wdata=0x1234_ABCD -> read mem_addr=1, then write mem_wdata=0xABCD_22F1; resp rdata=0, err=0; total 4 cycles accept→resp with zero-wait bus.
- Store word addr 0x8, wdata=0xDEAD_BEEF -> no read; single write at mem_addr=2 with 0xDEAD_BEEF; resp 2 cycles after accept.
- Illegal accesses: load half at 0x3, load word at 0x2, size=11 -> each gives resp_valid the next cycle with err=1, rdata=0, and mem_req never asserted.
- TIMEOUT=4, mem_gnt held low -> mem_req high 4 cycles, then dropped; resp err=1. TIMEOUT=0 with mem_gnt delayed 1000 cycles -> completes normally.
- Assert rst_n=0 while in RD_WAIT -> mem_req=0 and cpu_ready=1 immediately; no resp_valid. After release, a load of word 0 completes with correct data.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Serialises CPU loads/stores onto a single-ported word bus: sub-word loads are
// extracted and extended, sub-word stores become read-modify-write, with a bus timeout.
module mem_access_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_zext,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_resp_valid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        boff_q, boff_d;
    logic [1:0]        size_q, size_d;
    logic              zext_q, zext_d;
    logic              we_q, we_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic illegal, timeout, to_err;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic zx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   r = {{24{~zx & b[7]}}, b};
            2'b01:   r = {{16{~zx & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] d,
                                          input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) r[{off, 3'b000} +: 8]     = d[7:0];
        else             r[{off[1], 4'b0000} +: 16] = d;
        return r;
    endfunction

    assign illegal = (cpu_size == 2'b11) ||
                     (cpu_size == 2'b01 && cpu_addr[0]) ||
                     (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00);
    assign timeout = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        boff_d       = boff_q;
        size_d       = size_q;
        zext_d       = zext_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        ready_d      = ready_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        to_err       = 1'b0;

        case (state_q)
            IDLE: if (cpu_valid) begin
                boff_d  = cpu_addr[1:0];
                size_d  = cpu_size;
                zext_d  = cpu_zext;
                we_d    = cpu_we;
                wdata_d = cpu_wdata[15:0];
                ready_d = 1'b0;
                if (illegal) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    err_d        = 1'b1;
                    rdata_d      = '0;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = cpu_addr[ADDR_W-1:2];
                    // Full-word stores need no read; everything else reads first.
                    if (cpu_we && cpu_size == 2'b10) begin
                        state_d     = WR_REQ;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = cpu_wdata;
                    end else begin
                        state_d  = RD_REQ;
                        mem_we_d = 1'b0;
                    end
                end
            end
            RD_REQ: begin
                if (mem_gnt) begin
                    state_d   = RD_WAIT;
                    mem_req_d = 1'b0;
                end else if (timeout) begin
                    to_err = 1'b1;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    if (we_q) begin
                        state_d     = WR_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = merge(mem_rdata, wdata_q, size_q, boff_q);
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        err_d        = 1'b0;
                        rdata_d      = extract(mem_rdata, size_q, boff_q, zext_q);
                    end
                end else if (timeout) begin
                    to_err = 1'b1;
                end
            end
            WR_REQ: begin
                if (mem_gnt) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    err_d        = 1'b0;
                    rdata_d      = '0;
                end else if (timeout) begin
                    to_err = 1'b1;
                end
            end
            RESP: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                ready_d      = 1'b1;
                err_d        = 1'b0;
                rdata_d      = '0;
            end
            default: state_d = IDLE;
        endcase

        if (to_err) begin
            state_d      = RESP;
            mem_req_d    = 1'b0;
            mem_we_d     = 1'b0;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            rdata_d      = '0;
        end

        // Counter restarts on any state change and only runs while waiting on the bus.
        if (state_d != state_q)
            cnt_d = '0;
        else if (TIMEOUT != 0 && (state_q == RD_REQ || state_q == RD_WAIT || state_q == WR_REQ))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            boff_q       <= '0;
            size_q       <= '0;
            zext_q       <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            boff_q       <= boff_d;
            size_q       <= size_d;
            zext_q       <= zext_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign cpu_ready      = ready_q;
    assign cpu_resp_valid = resp_valid_q;
    assign cpu_rdata      = rdata_q;
    assign cpu_err        = err_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule
